stopwatch_counter: RTL and testbench

Counts elapsed time as minutes:seconds in four BCD digits, advancing once per rising edge of the slow square wave from the upstream clock divider. It is the stage directly downstream of that divider. The divider output is treated as data in the system-clock domain and is never used as a clock. Digit outputs feed the seven-segment display driver.

---
 rtl/stopwatch_pkg.sv | 28 ++
 rtl/tick_edge_detect.sv | 57 +++++
 rtl/stopwatch_counter.sv | 127 ++++++++++++
 tb/tb_stopwatch_counter.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/stopwatch_pkg.sv
// ============================================================================
// stopwatch_pkg : BCD digit type, digit limits and limit-splitting helper
// Revision 1.0
// ============================================================================
`default_nettype none

package stopwatch_pkg;

    typedef logic [3:0] bcd_t;

    typedef struct packed {
        bcd_t tens;
        bcd_t ones;
    } bcd_pair_t;

    localparam bcd_t SEC_TENS_MAX = 4'd5;
    localparam bcd_t BCD_MAX      = 4'd9;

    function automatic bcd_pair_t split_limit(input int unsigned limit);
        bcd_pair_t r;
        r.tens = bcd_t'(limit / 10);
        r.ones = bcd_t'(limit % 10);
        return r;
    endfunction

endpackage

`default_nettype wire

// File: rtl/tick_edge_detect.sv
// ============================================================================
// tick_edge_detect : samples slow_clk into clk domain, emits one-cycle tick_c
// per rising edge. Macro TICK_SYNC_EN selects a two-flop synchronizer.
// Revision 1.0
// ============================================================================
`default_nettype none

module tick_edge_detect (
    input  logic clk,
    input  logic rst_n,
    input  logic slow_clk,
    output logic tick_c
);

    logic s2_d, s2_q;
    logic s3_d, s3_q;

`ifdef TICK_SYNC_EN
    logic s1_d, s1_q;

    always_comb begin
        s1_d = slow_clk;
        s2_d = s1_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_q <= 1'b0;
        end else begin
            s1_q <= s1_d;
        end
    end
`else
    always_comb begin
        s2_d = slow_clk;
    end
`endif

    always_comb begin
        s3_d = s2_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_q <= 1'b0;
            s3_q <= 1'b0;
        end else begin
            s2_q <= s2_d;
            s3_q <= s3_d;
        end
    end

    assign tick_c = s2_q & ~s3_q;

endmodule

`default_nettype wire

// File: rtl/stopwatch_counter.sv
// ============================================================================
// stopwatch_counter : MM:SS BCD stopwatch advanced by slow_clk rising edges,
// with clear/adjust/pause. Macro TICK_SYNC_EN adds a synchronizer stage.
// Revision 1.0
// ============================================================================
`default_nettype none

module stopwatch_counter
    import stopwatch_pkg::*;
#(
    parameter int unsigned MIN_LIMIT = 59
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       slow_clk,
    input  logic       pause,
    input  logic       clear,
    input  logic       adj_sec,
    input  logic       adj_min,
    output logic [3:0] sec_ones,
    output logic [3:0] sec_tens,
    output logic [3:0] min_ones,
    output logic [3:0] min_tens,
    output logic       tick_o,
    output logic       rollover
);

    localparam bcd_pair_t LIMIT_BCD = split_limit(MIN_LIMIT);

    logic tick_c;

    bcd_t sec_ones_d, sec_ones_q;
    bcd_t sec_tens_d, sec_tens_q;
    bcd_t min_ones_d, min_ones_q;
    bcd_t min_tens_d, min_tens_q;
    logic tick_o_d,   tick_o_q;
    logic rollover_d, rollover_q;

    logic sec_at_max;
    logic min_at_limit;
    logic do_sec;
    logic do_min;
    logic tick_ok;
    logic adj_any;

    tick_edge_detect u_tick_edge_detect (
        .clk      (clk),
        .rst_n    (rst_n),
        .slow_clk (slow_clk),
        .tick_c   (tick_c)
    );

    always_comb begin
        sec_ones_d   = sec_ones_q;
        sec_tens_d   = sec_tens_q;
        min_ones_d   = min_ones_q;
        min_tens_d   = min_tens_q;
        tick_o_d     = 1'b0;
        rollover_d   = 1'b0;

        sec_at_max   = (sec_ones_q == BCD_MAX) && (sec_tens_q == SEC_TENS_MAX);
        min_at_limit = (min_tens_q == LIMIT_BCD.tens) && (min_ones_q == LIMIT_BCD.ones);
        adj_any      = adj_sec | adj_min;
        tick_ok      = tick_c & ~pause & ~adj_any & ~clear;

        // Adjust increments each field alone; only a tick carries seconds into minutes.
        do_sec = ~clear & (adj_any ? adj_sec : tick_ok);
        do_min = ~clear & (adj_any ? adj_min : (tick_ok & sec_at_max));

        if (clear) begin
            sec_ones_d = '0;
            sec_tens_d = '0;
            min_ones_d = '0;
            min_tens_d = '0;
        end else begin
            if (do_sec) begin
                if (sec_ones_q == BCD_MAX) begin
                    sec_ones_d = '0;
                    sec_tens_d = (sec_tens_q == SEC_TENS_MAX) ? '0 : sec_tens_q + 4'd1;
                end else begin
                    sec_ones_d = sec_ones_q + 4'd1;
                end
            end
            if (do_min) begin
                if (min_at_limit) begin
                    min_ones_d = '0;
                    min_tens_d = '0;
                end else if (min_ones_q == BCD_MAX) begin
                    min_ones_d = '0;
                    min_tens_d = min_tens_q + 4'd1;
                end else begin
                    min_ones_d = min_ones_q + 4'd1;
                end
            end
            tick_o_d   = tick_ok;
            rollover_d = tick_ok & sec_at_max & min_at_limit;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sec_ones_q <= '0;
            sec_tens_q <= '0;
            min_ones_q <= '0;
            min_tens_q <= '0;
            tick_o_q   <= 1'b0;
            rollover_q <= 1'b0;
        end else begin
            sec_ones_q <= sec_ones_d;
            sec_tens_q <= sec_tens_d;
            min_ones_q <= min_ones_d;
            min_tens_q <= min_tens_d;
            tick_o_q   <= tick_o_d;
            rollover_q <= rollover_d;
        end
    end

    assign sec_ones = sec_ones_q;
    assign sec_tens = sec_tens_q;
    assign min_ones = min_ones_q;
    assign min_tens = min_tens_q;
    assign tick_o   = tick_o_q;
    assign rollover = rollover_q;

endmodule

`default_nettype wire

// File: tb/tb_stopwatch_counter.sv
// ============================================================================
// tb_stopwatch_counter : directed self-checking bench for stopwatch_counter
// Revision 1.0
// ============================================================================
`default_nettype none

module tb_stopwatch_counter;

`ifdef TICK_SYNC_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    logic       clk = 1'b0;
    logic       rst_n;
    logic       slow_clk;
    logic       pause;
    logic       clear;
    logic       adj_sec;
    logic       adj_min;
    logic [3:0] sec_ones, sec_tens, min_ones, min_tens;
    logic       tick_o;
    logic       rollover;

    int n_cmp = 0;
    int n_err = 0;

    int tick_cnt = 0;
    int roll_cnt = 0;
    int wide_cnt = 0;
    int bad_roll = 0;
    logic prev_tick = 1'b0;

    int t0, r0;

    stopwatch_counter #(.MIN_LIMIT(59)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .slow_clk (slow_clk),
        .pause    (pause),
        .clear    (clear),
        .adj_sec  (adj_sec),
        .adj_min  (adj_min),
        .sec_ones (sec_ones),
        .sec_tens (sec_tens),
        .min_ones (min_ones),
        .min_tens (min_tens),
        .tick_o   (tick_o),
        .rollover (rollover)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (tick_o) tick_cnt++;
        if (rollover) roll_cnt++;
        if (tick_o && prev_tick) wide_cnt++;
        if (rollover && !tick_o) bad_roll++;
        prev_tick = tick_o;
    end

    function automatic logic [15:0] digits();
        return {min_tens, min_ones, sec_tens, sec_ones};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick_edge();
        slow_clk = 1'b1;
        repeat (3) @(negedge clk);
        slow_clk = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    task automatic adj_pulse(input logic s, input logic m, input int n);
        for (int i = 0; i < n; i++) begin
            adj_sec = s;
            adj_min = m;
            @(negedge clk);
            adj_sec = 1'b0;
            adj_min = 1'b0;
            @(negedge clk);
        end
    endtask

    initial begin
        rst_n = 1'b0; slow_clk = 1'b0; pause = 1'b0;
        clear = 1'b0; adj_sec = 1'b0; adj_min = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_digits", 32'(digits()), 32'h0000);
        check("reset_tick_o", 32'(tick_o), 32'h0);
        check("reset_rollover", 32'(rollover), 32'h0);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);

        // 60 ticks from 00:00
        t0 = tick_cnt;
        for (int i = 0; i < 60; i++) tick_edge();
        check("count60_digits", 32'(digits()), 32'h0100);
        check("count60_ticks", 32'(tick_cnt - t0), 32'd60);
        check("count60_width", 32'(wide_cnt), 32'd0);
        check("count60_noroll", 32'(roll_cnt), 32'd0);

        // preload 59:58 via both adjusts, then roll over
        t0 = tick_cnt;
        adj_pulse(1'b1, 1'b1, 58);
        check("preload_digits", 32'(digits()), 32'h5958);
        check("preload_no_tick", 32'(tick_cnt - t0), 32'd0);
        tick_edge();
        check("tick_5959", 32'(digits()), 32'h5959);
        check("roll_before", 32'(roll_cnt), 32'd0);
        tick_edge();
        check("tick_wrap", 32'(digits()), 32'h0000);
        check("roll_once", 32'(roll_cnt), 32'd1);
        check("roll_coincident", 32'(bad_roll), 32'd0);

        // pause discards ticks
        t0 = tick_cnt;
        pause = 1'b1;
        for (int i = 0; i < 5; i++) tick_edge();
        pause = 1'b0;
        @(negedge clk);
        check("pause_digits", 32'(digits()), 32'h0000);
        check("pause_no_tick", 32'(tick_cnt - t0), 32'd0);
        tick_edge();
        check("after_pause", 32'(digits()), 32'h0001);

        // adj_sec coincident with tick_c at 00:07
        for (int i = 0; i < 6; i++) tick_edge();
        check("at_0007", 32'(digits()), 32'h0007);
        t0 = tick_cnt;
        slow_clk = 1'b1;
        repeat (LAT) @(negedge clk);
        adj_sec = 1'b1;
        @(negedge clk);
        adj_sec = 1'b0;
        repeat (3) @(negedge clk);
        slow_clk = 1'b0;
        repeat (3) @(negedge clk);
        check("adj_over_tick", 32'(digits()), 32'h0008);
        check("adj_over_tick_o", 32'(tick_cnt - t0), 32'd0);
        adj_pulse(1'b1, 1'b0, 51);
        check("adj_0059", 32'(digits()), 32'h0059);
        adj_pulse(1'b1, 1'b0, 1);
        check("adj_sec_wrap", 32'(digits()), 32'h0000);

        // adj_min wraps at MIN_LIMIT
        adj_pulse(1'b0, 1'b1, 59);
        check("adj_min_59", 32'(digits()), 32'h5900);
        adj_pulse(1'b0, 1'b1, 1);
        check("adj_min_wrap", 32'(digits()), 32'h0000);

        // clear beats coincident adj_min and tick
        tick_edge();
        adj_pulse(1'b1, 1'b1, 3);
        check("pre_clear", 32'(digits()), 32'h0304);
        t0 = tick_cnt;
        slow_clk = 1'b1;
        repeat (LAT) @(negedge clk);
        clear = 1'b1;
        adj_min = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        adj_min = 1'b0;
        repeat (3) @(negedge clk);
        slow_clk = 1'b0;
        repeat (3) @(negedge clk);
        check("clear_digits", 32'(digits()), 32'h0000);
        check("clear_no_tick", 32'(tick_cnt - t0), 32'd0);

        // asynchronous reset while tick_o is high
        tick_edge();
        slow_clk = 1'b1;
        repeat (LAT + 1) @(negedge clk);
        check("pre_rst_tick_o", 32'(tick_o), 32'h1);
        check("pre_rst_digits", 32'(digits()), 32'h0002);
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_digits", 32'(digits()), 32'h0000);
        check("async_rst_tick_o", 32'(tick_o), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (LAT + 3) @(negedge clk);
        check("release_high_tick", 32'(digits()), 32'h0001);
        slow_clk = 1'b0;
        repeat (3) @(negedge clk);

        // latency: first sampling edge N, update at N+LAT
        slow_clk = 1'b1;
        @(negedge clk);
        repeat (LAT - 1) @(negedge clk);
        check("lat_before", 32'(digits()), 32'h0001);
        @(negedge clk);
        check("lat_at", 32'(digits()), 32'h0002);
        check("lat_tick_o", 32'(tick_o), 32'h1);
        repeat (2) @(negedge clk);
        slow_clk = 1'b0;
        repeat (3) @(negedge clk);
        check("final_width", 32'(wide_cnt), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire
